// File: rtl/led_matrix_scan.sv
// Column-multiplexed LED matrix scan driver: BCM bit planes per column, global
// brightness scaling and a glitch-free front/back frame buffer swap at frame end.
module led_matrix_scan #(
    parameter int COLS   = 16,
    parameter int ROWS   = 64,
    parameter int PIX_W  = 8,
    parameter int DIV    = 2,
    parameter int BASE_T = 4,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int AW = 1 + CW + RW
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic [7:0]       bright,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             frame_done,
    output logic             front_buf,
    output logic [AW-1:0]    rd_addr,
    input  logic [PIX_W-1:0] rd_data,
    output logic [CW-1:0]    cols,
    output logic             sdi,
    output logic             sclk,
    output logic             le,
    output logic             oe
);
    localparam int PW = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int DW = $clog2(DIV);
    localparam int SW = $clog2((BASE_T << (PIX_W - 1)) + 1);

    typedef enum logic [1:0] {ST_SHIFT, ST_LATCH, ST_SHOW} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q;
    logic [1:0]      ph_q, ph_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d, cols_q, cols_d;
    logic [PW-1:0]   plane_q, plane_d;
    logic [SW-1:0]   show_q, show_d, on_q, on_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            fb_q, fb_d, sdi_q, sdi_d, sclk_q, sclk_d;
    logic            le_q, le_d, oe_q, oe_d, done_q, done_d, ack_q, ack_d;
    logic            tick;
    logic [SW-1:0]   show_len, on_calc, on_cur;
    logic [SW+8:0]   on_prod;

    assign tick = (div_q == '0);

    // Full-width product so short planes are not truncated before the >>8.
    assign show_len = SW'(BASE_T) << plane_q;
    assign on_prod  = {9'd0, show_len} * {{SW{1'b0}}, ({1'b0, bright} + 9'd1)};
    assign on_calc  = SW'(on_prod >> 8);

    always_ff @(posedge clk_50) begin
        if (rst) begin
            div_q   <= '0;
            state_q <= ST_SHIFT;
            ph_q    <= '0;
            row_q   <= RW'(ROWS - 1);
            col_q   <= '0;
            plane_q <= '0;
            show_q  <= '0;
            on_q    <= '0;
            addr_q  <= '0;
            cols_q  <= '0;
            fb_q    <= 1'b0;
            sdi_q   <= 1'b0;
            sclk_q  <= 1'b0;
            le_q    <= 1'b0;
            oe_q    <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            div_q   <= (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
            state_q <= state_d;
            ph_q    <= ph_d;
            row_q   <= row_d;
            col_q   <= col_d;
            plane_q <= plane_d;
            show_q  <= show_d;
            on_q    <= on_d;
            addr_q  <= addr_d;
            cols_q  <= cols_d;
            fb_q    <= fb_d;
            sdi_q   <= sdi_d;
            sclk_q  <= sclk_d;
            le_q    <= le_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        row_d   = row_q;
        col_d   = col_q;
        plane_d = plane_q;
        show_d  = show_q;
        on_d    = on_q;
        addr_d  = addr_q;
        cols_d  = cols_q;
        fb_d    = fb_q;
        sdi_d   = sdi_q;
        sclk_d  = sclk_q;
        le_d    = le_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        // bright is captured on the first SHOW tick and held for the plane.
        on_cur  = (show_q == '0) ? on_calc : on_q;
        if (tick) begin
            case (state_q)
                ST_SHIFT: begin
                    oe_d = 1'b1;
                    le_d = 1'b0;
                    case (ph_q)
                        2'd0: begin
                            addr_d = {fb_q, col_q, row_q};
                            sclk_d = 1'b0;
                            ph_d   = 2'd1;
                        end
                        2'd1: begin
                            sdi_d = rd_data[plane_q];
                            ph_d  = 2'd2;
                        end
                        default: begin
                            sclk_d = 1'b1;
                            ph_d   = 2'd0;
                            if (row_q == '0) begin
                                row_d   = RW'(ROWS - 1);
                                state_d = ST_LATCH;
                            end else begin
                                row_d = row_q - RW'(1);
                            end
                        end
                    endcase
                end
                ST_LATCH: begin
                    le_d    = 1'b1;
                    sclk_d  = 1'b0;
                    oe_d    = 1'b1;
                    cols_d  = col_q;
                    show_d  = '0;
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    le_d = 1'b0;
                    on_d = on_cur;
                    oe_d = !(show_q < on_cur);
                    if (show_q == show_len - SW'(1)) begin
                        show_d  = '0;
                        state_d = ST_SHIFT;
                        if (plane_q == PW'(PIX_W - 1)) begin
                            plane_d = '0;
                            if (col_q == CW'(COLS - 1)) begin
                                col_d  = '0;
                                done_d = 1'b1;
                                if (swap_req) begin
                                    fb_d  = ~fb_q;
                                    ack_d = 1'b1;
                                end
                            end else begin
                                col_d = col_q + CW'(1);
                            end
                        end else begin
                            plane_d = plane_q + PW'(1);
                        end
                    end else begin
                        show_d = show_q + SW'(1);
                    end
                end
                default: state_d = ST_SHIFT;
            endcase
        end
    end

    assign swap_ack   = ack_q;
    assign frame_done = done_q;
    assign front_buf  = fb_q;
    assign rd_addr    = addr_q;
    assign cols       = cols_q;
    assign sdi        = sdi_q;
    assign sclk       = sclk_q;
    assign le         = le_q;
    assign oe         = oe_q;
endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: per-plane and per-frame expectations are
// queued by the stimulus and checked by an independent output monitor.
module tb_led_matrix_scan;
    localparam int COLS = 2, ROWS = 4, PIX_W = 2, DIV = 2, BASE_T = 2;
    localparam int CW = 1, RW = 2, AW = 1 + CW + RW;
    localparam int NF = 6;

    typedef struct packed {
        logic [ROWS-1:0]    sdi;
        logic [ROWS*AW-1:0] addr;
        logic [CW-1:0]      col;
        int                 oe_clks;
    } prec_t;

    typedef struct packed {
        logic swap;
        logic fb;
    } frec_t;

    logic             clk_50 = 1'b0;
    logic             rst;
    logic [7:0]       bright;
    logic             swap_req;
    logic             swap_ack, frame_done, front_buf;
    logic [AW-1:0]    rd_addr;
    logic [PIX_W-1:0] rd_data;
    logic [CW-1:0]    cols;
    logic             sdi, sclk, le, oe;

    logic [PIX_W-1:0] mem [2*COLS*ROWS];
    prec_t            pq[$];
    frec_t            fq[$];
    int               n_cmp = 0, n_err = 0;
    int               fb_m = 0;
    bit               mon_en = 1'b1;

    led_matrix_scan #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .DIV(DIV), .BASE_T(BASE_T)) dut (
        .clk_50(clk_50), .rst(rst), .bright(bright), .swap_req(swap_req),
        .swap_ack(swap_ack), .frame_done(frame_done), .front_buf(front_buf),
        .rd_addr(rd_addr), .rd_data(rd_data), .cols(cols), .sdi(sdi),
        .sclk(sclk), .le(le), .oe(oe)
    );

    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) rd_data <= mem[rd_addr];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: pixel bit b of rows ROWS-1..0, in shift order, plus scaled on-time.
    function automatic prec_t model_plane(input int fb, input int c, input int b, input int br);
        prec_t r;
        logic [PIX_W-1:0] px;
        int a;
        r = '0;
        for (int k = 0; k < ROWS; k++) begin
            a  = fb * COLS * ROWS + c * ROWS + (ROWS - 1 - k);
            px = mem[a];
            r.sdi[ROWS-1-k] = px[b];
            r.addr[(ROWS-1-k)*AW +: AW] = AW'(a);
        end
        r.col     = CW'(c);
        r.oe_clks = (((BASE_T << b) * (br + 1)) >> 8) * DIV;
        return r;
    endfunction

    task automatic push_frame(input int br, input bit sw);
        frec_t fr;
        for (int c = 0; c < COLS; c++)
            for (int b = 0; b < PIX_W; b++)
                pq.push_back(model_plane(fb_m, c, b, br));
        fb_m    = fb_m ^ int'(sw);
        fr.swap = sw;
        fr.fb   = fb_m[0];
        fq.push_back(fr);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_50);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Monitor state
    bit                 prev_sclk, pend, fin_act;
    int                 rises, le_clks, oe_clks, fin_left;
    logic [ROWS-1:0]    obs_sdi;
    logic [ROWS*AW-1:0] obs_addr;
    logic [CW-1:0]      le_col, prev_cols;

    task automatic finalize_plane();
        prec_t e;
        if (mon_en) begin
            if (pq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL plane_queue: plane observed with no expected record");
            end else begin
                e = pq.pop_front();
                chk("sclk_rises", rises, ROWS);
                chk("sdi_bits", obs_sdi, e.sdi);
                chk("rd_addr_seq", obs_addr, e.addr);
                chk("latched_col", le_col, e.col);
                chk("le_width", le_clks, DIV);
                chk("oe_low_clks", oe_clks, e.oe_clks);
            end
        end
        pend     = 1'b0;
        rises    = 0;
        obs_sdi  = '0;
        obs_addr = '0;
    endtask

    initial begin
        frec_t f;
        forever begin
            @(negedge clk_50);
            if (rst) begin
                prev_sclk = 1'b0; pend = 1'b0; fin_act = 1'b0; rises = 0;
                obs_sdi = '0; obs_addr = '0; prev_cols = '0;
            end else begin
                if (cols != prev_cols) chk("cols_change_blanked", oe, 1);
                prev_cols = cols;
                if (sclk && !prev_sclk) begin
                    if (pend) finalize_plane();
                    obs_sdi  = {obs_sdi[ROWS-2:0], sdi};
                    obs_addr = {obs_addr[(ROWS-1)*AW-1:0], rd_addr};
                    rises++;
                end
                if (le) begin
                    if (!pend) begin
                        pend = 1'b1; le_col = cols; le_clks = 0; oe_clks = 0;
                    end
                    le_clks++;
                end
                if (pend && !oe) oe_clks++;
                if (fin_act) begin
                    fin_left--;
                    if (fin_left == 0) begin
                        fin_act = 1'b0;
                        finalize_plane();
                    end
                end else if (frame_done && mon_en) begin
                    if (fq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL frame_queue: frame_done with no expected frame");
                    end else begin
                        f = fq.pop_front();
                        chk("swap_ack", swap_ack, f.swap);
                        chk("front_buf", front_buf, f.fb);
                    end
                    fin_act  = 1'b1;
                    fin_left = DIV - 1;
                end
                if (swap_ack) chk("swap_ack_with_done", frame_done, 1);
                prev_sclk = sclk;
            end
        end
    end

    initial begin
        int first, br, dly;
        bit sw, ok, got;
        for (int i = 0; i < 2 * COLS * ROWS; i++) mem[i] = PIX_W'($urandom);
        mem[3] = {mem[3][1], 1'b1};
        mem[2] = {mem[2][1], 1'b0};
        mem[1] = {mem[1][1], 1'b1};
        mem[0] = {mem[0][1], 1'b1};
        rst = 1'b1; bright = 8'd255; swap_req = 1'b0;
        repeat (3) @(posedge clk_50);
        @(negedge clk_50);
        chk("rst_oe", oe, 1);
        chk("rst_le", le, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_front_buf", front_buf, 0);
        chk("rst_cols", cols, 0);
        chk("rst_rd_addr", rd_addr, 0);
        push_frame(255, 1'b1);
        rst = 1'b0;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_50);
            if (sclk && first < 0) first = i;
        end
        chk("first_sclk_clk", first, 4);
        swap_req = 1'b1;
        ok = 1'b1;
        for (int fr = 0; fr < NF && ok; fr++) begin
            if (fr > 0) begin
                br = (fr == 1) ? 127 : (fr == 2) ? 0 : int'($urandom_range(0, 255));
                sw = (fr == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                bright = 8'(br);
                push_frame(br, sw);
                dly = $urandom_range(1, 100);
                repeat (dly) @(negedge clk_50);
                swap_req = sw;
            end
            wait_done(ok);
            if (!ok) chk("frame_done_timeout", 0, 1);
            swap_req = 1'b0;
        end
        bright = 8'd255;
        repeat (DIV + 2) @(negedge clk_50);
        mon_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_50);
            if (!oe) begin
                got = 1'b1;
                break;
            end
        end
        chk("oe_low_seen", got, 1);
        rst = 1'b1;
        @(negedge clk_50);
        chk("midrst_oe", oe, 1);
        chk("midrst_cols", cols, 0);
        chk("midrst_le", le, 0);
        chk("midrst_front_buf", front_buf, 0);
        fb_m = 0;
        pq.delete();
        fq.delete();
        pq.push_back(model_plane(0, 0, 0, 255));
        mon_en = 1'b1;
        @(negedge clk_50);
        rst = 1'b0;
        for (int i = 0; i < 200 && pq.size() != 0; i++) @(negedge clk_50);
        chk("plane_queue_drained", pq.size(), 0);
        chk("frame_queue_drained", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Parametrised successor to the 4-column/64-row seven-matrix scan driver.
- Scans COLS columns, each column a ROWS-bit shift chain of PIX_W-bit pixels.
- Replaces fixed-threshold dimming with binary-code-modulation (BCM) bit planes and a global brightness scale.
- Reads pixels from an external double-buffered frame RAM and swaps buffers glitch-free at frame boundaries on request.

Parameters:
- COLS, 16: number of columns driven on cols.
- ROWS, 64: shift-register bits per column.
- PIX_W, 8: pixel depth; one BCM plane per bit.
- DIV, 2: clk_50 cycles per scan tick; minimum 2.
- BASE_T, 4: ticks of SHOW for plane 0; plane b shows for BASE_T<<b ticks.

Ports:
- clk_50  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- bright  in  8  global brightness scale.
- swap_req  in  1  level request to swap front/back buffer; hold high until swap_ack.
- swap_ack  out  1  1-clk pulse when the swap takes effect.
- frame_done  out  1  1-clk pulse at the end of each full frame.
- front_buf  out  1  buffer currently scanned.
- rd_addr  out  1+clog2(COLS)+clog2(ROWS)  frame RAM read address {front_buf, col, row}.
- rd_data  in  PIX_W  pixel word; valid 1 clk after rd_addr (registered RAM).
- cols  out  max(1,clog2(COLS))  active column index.
- sdi  out  1  serial row data.
- sclk  out  1  shift clock.
- le  out  1  latch enable, active high.
- oe  out  1  output enable, active low (1 = blank).

Behaviour:
- Reset: cols=0, sdi=0, sclk=0, le=0, oe=1, rd_addr=0, front_buf=0, swap_ack=0, frame_done=0, tick prescaler=0, state=SHIFT, col=0, plane=0, row=ROWS-1.
- Reset asserted mid-operation: all outputs take reset values on the next clk_50 edge; oe therefore blanks within 1 clk.
- Tick: a 1-clk strobe every DIV clk_50 cycles. All state and output changes occur on tick edges only, except the 1-clk pulses.
- Scan order: for col 0..COLS-1, for plane b 0..PIX_W-1, run SHIFT -> LATCH -> SHOW.
- SHIFT (oe=1): rows are shifted ROWS-1 first, down to row 0, at 3 ticks per bit.
  - Phase A: rd_addr={front_buf,col,row}, sclk=0.
  - Phase B: sdi=rd_data[b], sclk=0.
  - Phase C: sclk=1.
  - Duration 3*ROWS ticks. sdi is held through phase C.
- LATCH: 1 tick.
  - le=1, sclk=0, oe=1.
  - cols updated to col in this tick; cols only changes while blanked.
- SHOW: BASE_T<<b ticks.
  - on = ((BASE_T<<b)*(bright+1))>>8, computed at full width with no truncation before the shift.
  - bright is sampled on SHOW entry.
  - oe=0 while show_cnt<on, else oe=1; le=0.
  - on=0 means the plane stays blank for its whole SHOW.
- Plane and column sequencing:
  - After SHOW of plane PIX_W-1, col increments and plane resets to 0.
  - col wraps from COLS-1 to 0.
- Frame end (SHOW of last plane of col COLS-1 completes):
  - frame_done pulses for 1 clk.
  - If swap_req=1 at that clk, front_buf toggles and swap_ack pulses in the same clk.
  - swap_req arriving mid-frame waits for the frame end. swap_req=0 means no toggle.
- Frame length: COLS*sum_b(3*ROWS+1+(BASE_T<<b)) ticks.
- Widths: internal counters are sized from the parameters via clog2. The show counter is wide enough for BASE_T<<(PIX_W-1).

Test Plan:
- Reset/idle, with COLS=2, ROWS=4, PIX_W=2, DIV=2, BASE_T=2: assert rst for 3 clks.
  - Required: oe=1, le=0, sclk=0, front_buf=0.
  - Required after release: first sclk rise at clk 4–5 (tick 2).
- Shift data: RAM col0 rows 3..0 = 1,0,1,1, same params.
  - Plane 0: sdi at the 4 sclk rises = 1,0,1,1.
  - le high for exactly 2 clks after the 4th rise.
  - Plane 0 SHOW lasts 2 ticks; plane 1 SHOW lasts 4 ticks.
- Brightness, same params:
  - bright=255: oe low 2 ticks in plane 0 and 4 ticks in plane 1.
  - bright=127: oe low 1 and 2 ticks.
  - bright=0: oe never low.
- Frame and swap, same params: frame period is 64 ticks = 128 clks.
  - swap_req raised at clk 30 gives swap_ack coincident with the first frame_done.
  - front_buf=1 after that pulse, and rd_addr MSB=1 from then on.
- Column sequencing: cols changes only in clks where oe=1.
  - cols sequence 0,1,0, changing after 2 planes each.
- Reset mid-SHOW: assert rst while oe=0.
  - Next clk: oe=1 and cols=0.
  - After release, scan restarts at col 0, plane 0, row 3.
